// File: rtl/lr3_disp_pkg.sv
// lr3_disp_pkg: shared constants, scan FSM state type and the active-low 7-segment glyph table.
package lr3_disp_pkg;
  localparam int DIGITS = 8;
  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_e;
  // Glyphs are {g,f,e,d,c,b,a}, active-low, for nibble values 0..F.
  localparam logic [6:0] SEG_LUT [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/lr3_hex7seg.sv
// lr3_hex7seg: combinational hex nibble to active-low 7-segment decoder (nib_i -> seg_o {g,f,e,d,c,b,a}).
module lr3_hex7seg
  import lr3_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_LUT[nib_i];
endmodule

// File: rtl/lr3_disp_scan_ctrl.sv
// lr3_disp_scan_ctrl: 8-digit multiplexed 7-segment scanner with frame-synchronous shadow update.
// Ports: CLK, RST_N (async active-low), CE (scan enable), DISP_SEQ[31:0] (8 nibbles), DISP_OFF[7:0] (1 = dark),
//        UPD (load request) -> UPD_ACK (load pulse), AN[7:0] / SEG[6:0] (active-low, registered), FRAME (wrap pulse).
// Option: LR3_SCAN_BLINK_EN adds BLINK[7:0] and a 5-bit frame counter; flagged digits go dark while counter[4]=1.
module lr3_disp_scan_ctrl
  import lr3_disp_pkg::*;
#(
  parameter int PRESC = 50000,
  parameter int BLANK = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE,
  input  logic [31:0] DISP_SEQ,
  input  logic [7:0]  DISP_OFF,
  input  logic        UPD,
`ifdef LR3_SCAN_BLINK_EN
  input  logic [7:0]  BLINK,
`endif
  output logic        UPD_ACK,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        FRAME
);
  localparam logic [15:0] PMAX = 16'(PRESC - 1);
  localparam logic [15:0] BEND = 16'(BLANK - 1);
  logic [15:0] presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  state_e      state_q, state_d;
  logic [31:0] seq_q, seq_d;
  logic [7:0]  off_q, off_d, an_q, an_d;
  logic [6:0]  seg_q, seg_d, glyph;
  logic        pend_q, pend_d, ack_q, frame_q;
  logic        wrap, bound, load, dark;
  assign wrap  = CE && presc_q == PMAX;
  assign bound = wrap && idx_q == 3'(DIGITS - 1);
  // A request arriving on the boundary cycle itself is served immediately.
  assign load  = bound && (pend_q || UPD);
  lr3_hex7seg u_hex (.nib_i(seq_q[{idx_q, 2'b00} +: 4]), .seg_o(glyph));
`ifdef LR3_SCAN_BLINK_EN
  logic [4:0] fcnt_q;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) fcnt_q <= '0;
    else if (bound) fcnt_q <= fcnt_q + 5'd1;
  assign dark = off_q[idx_q] | (BLINK[idx_q] & fcnt_q[4]);
`else
  assign dark = off_q[idx_q];
`endif
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_q <= '0;
      idx_q   <= '0;
      state_q <= ST_BLANK;
      seq_q   <= '0;
      off_q   <= 8'hFF;
      pend_q  <= 1'b0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      ack_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      seq_q   <= seq_d;
      off_q   <= off_d;
      pend_q  <= pend_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      ack_q   <= load;
      frame_q <= bound;
    end
  end
  always_comb begin
    presc_d = CE ? (wrap ? '0 : presc_q + 16'd1) : presc_q;
    idx_d   = wrap ? idx_q + 3'd1 : idx_q;
    seq_d   = load ? DISP_SEQ : seq_q;
    off_d   = load ? DISP_OFF : off_q;
    pend_d  = load ? 1'b0 : (pend_q | UPD);
  end
  always_comb
    state_d = (state_q == ST_BLANK) ? ((CE && presc_q == BEND) ? ST_SHOW : ST_BLANK)
                                    : (wrap ? ST_BLANK : ST_SHOW);
  // Outputs are computed from the current state/index and registered, so they trail by one cycle.
  always_comb begin
    an_d  = CE ? ((state_q == ST_SHOW && !dark) ? ~(8'b1 << idx_q) : 8'hFF) : an_q;
    seg_d = CE ? ((state_q == ST_SHOW) ? glyph : 7'h7F) : seg_q;
  end
  assign AN      = an_q;
  assign SEG     = seg_q;
  assign UPD_ACK = ack_q;
  assign FRAME   = frame_q;
endmodule

// File: tb/tb_lr3_disp_scan_ctrl.sv
// tb_lr3_disp_scan_ctrl: randomized self-checking bench with a slot/frame arithmetic reference model.
module tb_lr3_disp_scan_ctrl;
  localparam int PRESC = 4;
  localparam int BLANK = 1;
  logic        clk = 0, rst_n = 0, ce = 0, upd = 0;
  logic [31:0] seq = 0;
  logic [7:0]  off = 0, blink = 0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        ack, frame;
  int checks = 0, failures = 0;
  int          ticks, fcnt;
  bit          pend, m_frame, m_ack;
  logic [31:0] sh_seq;
  logic [7:0]  sh_off, m_an;
  logic [6:0]  m_seg;
  logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  lr3_disp_scan_ctrl #(.PRESC(PRESC), .BLANK(BLANK)) dut (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .DISP_SEQ(seq), .DISP_OFF(off), .UPD(upd),
`ifdef LR3_SCAN_BLINK_EN
    .BLINK(blink),
`endif
    .UPD_ACK(ack), .AN(an), .SEG(seg), .FRAME(frame));

  always #5 clk = ~clk;

  task automatic model_reset();
    ticks = 0; fcnt = 0; pend = 0; sh_seq = '0; sh_off = 8'hFF;
    m_an = 8'hFF; m_seg = 7'h7F; m_frame = 0; m_ack = 0;
  endtask

  // Drive one cycle; the model sees the scan as position ticks%32 within a frame of 8 slots x PRESC.
  task automatic tick(input bit c, input bit u);
    int pos, i, ph;
    bit dk;
    ce = c; upd = u;
    m_frame = 0; m_ack = 0;
    if (c) begin
      pos = ticks % (8 * PRESC); i = pos / PRESC; ph = pos % PRESC;
      dk = sh_off[i] || (blink[i] && (fcnt % 32) >= 16);
      m_an  = (ph >= BLANK && !dk) ? ~(8'b1 << i) : 8'hFF;
      m_seg = (ph >= BLANK) ? glyph[sh_seq[4*i +: 4]] : 7'h7F;
      if (pos == 8 * PRESC - 1) begin
        m_frame = 1; fcnt++;
        if (pend || u) begin m_ack = 1; pend = 0; sh_seq = seq; sh_off = off; end
      end else pend = pend | u;
      ticks++;
    end else pend = pend | u;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (an !== 8'hFF || seg !== 7'h7F || ack !== 1'b0 || frame !== 1'b0) begin
      failures++; $display("FAIL reset an=%h seg=%h ack=%b frame=%b want FF/7F/0/0", an, seg, ack, frame);
    end
    rst_n = 1; model_reset();
  endtask

  task automatic test_blank_frames();
    int nf = 0;
    for (int k = 0; k < 64; k++) begin
      tick(1, 0);
      nf += frame;
      checks++;
      if (an !== 8'hFF || seg !== m_seg || frame !== m_frame || ack !== 1'b0) begin
        failures++; $display("FAIL blank k=%0d an=%h seg=%h/%h frame=%b/%b ack=%b", k, an, seg, m_seg, frame, m_frame, ack);
      end
    end
    checks++;
    if (nf !== 2) begin failures++; $display("FAIL blank_frame_count got=%0d want=2", nf); end
  endtask

  task automatic test_update();
    int nack = 0, n3 = 0, bad = 0;
    seq = 32'h76543210; off = 8'h00;
    for (int k = 0; k < 64; k++) begin
      tick(1, k == 0);
      nack += ack;
      if (ack && !frame) bad++;
      if (an == 8'hF7 && seg == 7'h30) n3++;
      checks++;
      if (an !== m_an || seg !== m_seg || frame !== m_frame || ack !== m_ack) begin
        failures++; $display("FAIL update k=%0d an=%h/%h seg=%h/%h frame=%b/%b ack=%b/%b", k, an, m_an, seg, m_seg, frame, m_frame, ack, m_ack);
      end
    end
    checks++;
    if (nack !== 1 || bad !== 0) begin failures++; $display("FAIL update_ack acks=%0d uncoincident=%0d want 1/0", nack, bad); end
    checks++;
    if (n3 !== 3) begin failures++; $display("FAIL digit3_show cycles=%0d want=3", n3); end
  endtask

  task automatic test_upd_hold();
    int nack = 0;
    seq = $urandom; off = 8'h00;
    for (int k = 0; k < 53; k++) begin
      tick(1, k >= 10 && k < 13);
      nack += ack;
      checks++;
      if (an !== m_an || seg !== m_seg || frame !== m_frame || ack !== m_ack) begin
        failures++; $display("FAIL upd_hold k=%0d an=%h/%h seg=%h/%h frame=%b/%b ack=%b/%b", k, an, m_an, seg, m_seg, frame, m_frame, ack, m_ack);
      end
    end
    checks++;
    if (nack !== 1) begin failures++; $display("FAIL upd_hold_acks got=%0d want=1", nack); end
  endtask

  task automatic test_ce_stall();
    logic [6:0] s0;
    int rem = 0;
    for (int k = 0; k < 64 && ticks % 32 != 5 * PRESC + 2; k++) tick(1, 0);
    s0 = glyph[sh_seq[23:20]];
    checks++;
    if (an !== 8'hDF || seg !== s0) begin failures++; $display("FAIL stall_pre an=%h seg=%h want DF/%h", an, seg, s0); end
    for (int k = 0; k < 10; k++) begin
      tick(0, 0);
      checks++;
      if (an !== 8'hDF || seg !== s0 || frame !== 1'b0) begin
        failures++; $display("FAIL stall k=%0d an=%h seg=%h frame=%b want DF/%h/0", k, an, seg, frame, s0);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick(1, 0);
      if (an == 8'hDF) rem++;
      checks++;
      if (an !== m_an || seg !== m_seg) begin failures++; $display("FAIL stall_resume k=%0d an=%h/%h seg=%h/%h", k, an, m_an, seg, m_seg); end
    end
    checks++;
    if (rem !== 2) begin failures++; $display("FAIL stall_remaining cycles=%0d want=2", rem); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) begin seq = $urandom; off = 8'($urandom) & 8'($urandom); end
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      checks++;
      if (an !== m_an || seg !== m_seg || frame !== m_frame || ack !== m_ack) begin
        failures++; $display("FAIL random k=%0d an=%h/%h seg=%h/%h frame=%b/%b ack=%b/%b", k, an, m_an, seg, m_seg, frame, m_frame, ack, m_ack);
      end
    end
  endtask

  task automatic test_reset_pending();
    int nack = 0;
    off = 8'h00;
    for (int k = 0; k < 64 && !(ticks % 32 > 2 && ticks % 32 < 28); k++) tick(1, 0);
    tick(1, 1);
    for (int k = 0; k < 8 && m_an == 8'hFF; k++) tick(1, 0);
    checks++;
    if (an !== m_an || an === 8'hFF || pend !== 1) begin failures++; $display("FAIL rstp_pre an=%h want %h lit pend=%b", an, m_an, pend); end
    #3 rst_n = 0;
    #1;
    checks++;
    if (an !== 8'hFF || seg !== 7'h7F) begin failures++; $display("FAIL rstp_async an=%h seg=%h want FF/7F", an, seg); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1; model_reset();
    for (int k = 0; k < 40; k++) begin
      tick(1, 0);
      nack += ack;
      checks++;
      if (an !== m_an || seg !== m_seg || frame !== m_frame || ack !== m_ack) begin
        failures++; $display("FAIL rstp_post k=%0d an=%h/%h seg=%h/%h frame=%b/%b ack=%b/%b", k, an, m_an, seg, m_seg, frame, m_frame, ack, m_ack);
      end
    end
    checks++;
    if (nack !== 0) begin failures++; $display("FAIL rstp_acks got=%0d want=0", nack); end
  endtask

`ifdef LR3_SCAN_BLINK_EN
  task automatic test_blink();
    int lit = 0;
    bit got = 0;
    blink = 8'h01; off = 8'h00; seq = $urandom;
    tick(1, 1);
    for (int k = 0; k < 64 && !got; k++) begin tick(1, 0); got = ack; end
    checks++;
    if (!got) begin failures++; $display("FAIL blink_load ack never seen within 64 cycles"); end
    for (int k = 0; k < 32 * 8 * PRESC; k++) begin
      tick(1, 0);
      if (an == 8'hFE) lit++;
      checks++;
      if (an !== m_an || seg !== m_seg) begin failures++; $display("FAIL blink k=%0d an=%h/%h seg=%h/%h", k, an, m_an, seg, m_seg); end
    end
    checks++;
    if (lit !== 16 * (PRESC - BLANK)) begin failures++; $display("FAIL blink_lit cycles=%0d want=%0d", lit, 16 * (PRESC - BLANK)); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_blank_frames();
    test_update();
    test_upd_hold();
    test_ce_stall();
    test_random();
    test_reset_pending();
`ifdef LR3_SCAN_BLINK_EN
    test_blink();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lr3_disp_scan_ctrl.md
LR3_DISP_SCAN_CTRL -- requirements
Module: lr3_disp_scan_ctrl

Interface
REQ-001 SHALL have parameter PRESC, default 50000: clock-enabled cycles per digit slot; legal range 2..65535.
REQ-002 SHALL have parameter BLANK, default 16: blanking cycles at the start of each slot; legal range 1..PRESC-1.
REQ-003 SHALL have port CLK  in  1  system clock, rising edge.
REQ-004 SHALL have port RST_N  in  1  asynchronous active-low reset.
REQ-005 SHALL have port CE  in  1  clock enable; the scan advances only when CE=1.
REQ-006 SHALL have port DISP_SEQ  in  32  eight hex nibbles; digit i = DISP_SEQ[4i+3:4i].
REQ-007 SHALL have port DISP_OFF  in  8  per-digit blank, 1 = digit dark.
REQ-008 SHALL have port UPD  in  1  request to load DISP_SEQ/DISP_OFF into the shadow registers.
REQ-009 SHALL have port UPD_ACK  out  1  one-cycle pulse when the shadow load occurs.
REQ-010 SHALL have port AN  out  8  digit anodes, active-low.
REQ-011 SHALL have port SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 SHALL have port FRAME  out  1  one-cycle pulse on digit index wrap 7->0.

Function
REQ-013 SHALL count a prescaler 0..PRESC-1 on CE=1, wrapping at PRESC-1 and incrementing a 3-bit digit index (7 wraps to 0) on that same cycle.
REQ-014 SHALL hold the prescaler, index, AN, SEG and the FSM when CE=0; UPD is still latched while CE=0.
REQ-015 SHALL use a two-state FSM: BLANK while prescaler < BLANK, SHOW otherwise; BLANK->SHOW when prescaler reaches BLANK; SHOW->BLANK on prescaler wrap.
REQ-016 SHALL drive AN=8'hFF and SEG=7'h7F in BLANK.
REQ-017 SHALL drive, in SHOW, AN[idx]=0 with all other AN bits 1, and SEG = hex decode of shadow nibble idx; shadow_off[idx]=1 forces AN=8'hFF.
REQ-018 SHALL register AN and SEG, so outputs lag the FSM/index by exactly one cycle.
REQ-019 SHALL decode 0-F to standard 7-segment glyphs; examples: 0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E.
REQ-020 SHALL set a pending flag on UPD=1; on the next frame boundary (index wrap with CE=1) it SHALL copy DISP_SEQ/DISP_OFF into shadow, clear pending and pulse UPD_ACK.
REQ-021 SHALL treat UPD coinciding with a frame boundary as loading on that same cycle.
REQ-022 SHALL treat repeated UPD while pending as one request: one load and one UPD_ACK.
REQ-023 SHALL pulse FRAME in the same cycle as the boundary; FRAME and UPD_ACK are coincident when a load occurs.

Reset
REQ-024 SHALL, on RST_N=0 and independent of CLK, set: prescaler 0, index 0, FSM BLANK, shadow_seq 32'h0, shadow_off 8'hFF, pending 0, AN 8'hFF, SEG 7'h7F, UPD_ACK 0, FRAME 0.
REQ-025 SHALL discard a pending update when reset asserts mid-frame.

Configuration
REQ-026 SHALL, when LR3_SCAN_BLINK_EN is defined, add input BLINK[7:0] and a 5-bit frame counter incremented on each FRAME; a digit with BLINK[i]=1 is dark while counter[4]=1. Counter resets to 0.
REQ-027 SHALL, when LR3_SCAN_BLINK_EN is undefined, have no BLINK port, no frame counter, and behave exactly per REQ-013..REQ-025.

Structure
REQ-028 SHALL place DIGITS=8, the FSM state enum and the 16-entry segment constant table in package lr3_disp_pkg.
REQ-029 SHALL instantiate one combinational sub-module lr3_hex7seg (4-bit in, 7-bit active-low out).

Verification (PRESC=4, BLANK=1)
REQ-030 Reset release, CE=1, no UPD -> AN stays 8'hFF for 2 full frames (shadow_off=FF); FRAME pulses every 32 cycles.
REQ-031 DISP_SEQ=32'h76543210, DISP_OFF=0, UPD pulse -> UPD_ACK+FRAME at first wrap; in the next frame digit 3 shows AN=8'hF7, SEG=7'h30 for 3 cycles after 1 blank cycle.
REQ-032 UPD held for 3 cycles mid-frame -> exactly one UPD_ACK, at the boundary.
REQ-033 CE low for 10 cycles during SHOW of digit 5 -> AN/SEG frozen; the slot resumes with its remaining count.
REQ-034 RST_N low mid-frame with pending=1 -> immediate AN=8'hFF; no UPD_ACK after release.
REQ-035 (LR3_SCAN_BLINK_EN) BLINK=8'h01, all digits on -> digit 0 dark during frames 16-31, lit during frames 0-15.
